// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared CPU constants for the memory stage (FSM encoding, default wait limit).
package mem_stage_pkg;
  localparam int DEFAULT_MAX_WAIT = 15;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  function automatic logic word_aligned(input logic [1:0] low);
    return low == 2'b00;
  endfunction
endpackage

// File: rtl/mem_stage_wait_timer.sv
// mem_wait_timer: counts unacknowledged access cycles and flags the last allowed one.
import mem_stage_pkg::*;
module mem_wait_timer #(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] count;
  // Cleared on entry to ACCESS, advanced each access cycle that sees no ack.
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 1'b1;
  // The current cycle is the last one allowed: without an ack the count reaches MAX_WAIT.
  assign at_limit = count == W'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing aligned loads/stores and producing a registered writeback.
import mem_stage_pkg::*;
module mem_stage #(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        timeout
);
  logic [1:0]  state;
  logic [31:0] addr_r, wdata_r;
  logic        we_r, to_reg_r, reg_wr_r;
  logic [4:0]  wr_reg_r;
  logic        accept, mem_op, go_access, access, at_limit, expire;
  assign in_ready  = state == ST_IDLE;
  assign accept    = in_valid && in_ready;
  assign mem_op    = mem_write || mem_read;
  assign go_access = accept && mem_op && word_aligned(alu_result[1:0]);
  assign access    = state == ST_ACCESS;
  assign expire    = access && !mem_ack && at_limit;
  // Request lines come straight from the state so reset drops them without a clock.
  assign mem_req   = access;
  assign mem_we    = access && we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst(rst), .clear(go_access), .inc(access && !mem_ack), .at_limit(at_limit)
  );
  // Sequencing: aligned memory ops wait for ack or expiry; RESP lasts one cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else if (go_access) state <= ST_ACCESS;
    else if (access && mem_ack) state <= ST_RESP;
    else if (expire || state == ST_RESP) state <= ST_IDLE;
  // Operation snapshot taken at accept; write wins over read when both are set.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_r <= '0; wdata_r <= '0; we_r <= 1'b0; to_reg_r <= 1'b0; reg_wr_r <= 1'b0; wr_reg_r <= '0;
    end else if (accept) begin
      addr_r <= alu_result; wdata_r <= store_data; we_r <= mem_write;
      to_reg_r <= mem_to_reg; reg_wr_r <= reg_write; wr_reg_r <= write_reg;
    end
  // Writeback bundle and error pulses, valid for exactly the cycle after a completion.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_valid <= 1'b0; wb_reg_write <= 1'b0; wb_write_reg <= '0; wb_data <= '0;
      misaligned <= 1'b0; timeout <= 1'b0;
    end else begin
      wb_valid <= 1'b0; wb_reg_write <= 1'b0; misaligned <= 1'b0; timeout <= 1'b0;
      if (accept && !go_access) begin
        wb_valid <= 1'b1; misaligned <= mem_op; wb_data <= alu_result; wb_write_reg <= write_reg;
        wb_reg_write <= !mem_op && reg_write && write_reg != 5'd0;
      end else if (access && mem_ack) begin
        wb_valid <= 1'b1; wb_data <= to_reg_r ? mem_rdata : addr_r; wb_write_reg <= wr_reg_r;
        wb_reg_write <= !we_r && reg_wr_r && wr_reg_r != 5'd0;
      end else if (expire) begin
        wb_valid <= 1'b1; timeout <= 1'b1; wb_data <= addr_r; wb_write_reg <= wr_reg_r;
      end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15, max cycles mem_req may stay high without mem_ack before the access aborts.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 in_valid  input  1  upstream (ALU stage) presents an operation.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 alu_result  input  32  ALU result, used as byte address for memory ops and as writeback data otherwise.
REQ-007 store_data  input  32  second register operand, the store data.
REQ-008 mem_write, mem_read, mem_to_reg, reg_write  input  1 each  control bits from decode/control.
REQ-009 write_reg  input  5  destination register from the rt/rd select.
REQ-010 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-011 mem_addr, mem_wdata  output  32 each  word-aligned byte address and store data.
REQ-012 mem_ack  input  1; mem_rdata  input  32  memory completion and load data.
REQ-013 wb_valid, wb_reg_write  output  1 each; wb_write_reg  output  5; wb_data  output  32  registered writeback bundle.
REQ-014 misaligned, timeout  output  1 each  single-cycle error pulses.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; in_ready=1 only in IDLE.
REQ-016 Accept occurs on an edge with in_valid=1 and in_ready=1; all inputs are captured into internal registers at accept.
REQ-017 Non-memory op (mem_write=0, mem_read=0): FSM stays IDLE; next cycle wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write, wb_write_reg=write_reg (latency 1).
REQ-018 Memory op with alu_result[1:0]=0: IDLE->ACCESS; mem_req=1 from the cycle after accept until and including the mem_ack cycle; mem_addr, mem_we, mem_wdata stable throughout.
REQ-019 mem_write=1 with mem_read=1: write has priority, read is ignored.
REQ-020 mem_ack=1 in ACCESS: load data captured, ACCESS->RESP; in RESP wb_valid=1 for exactly one cycle, then RESP->IDLE.
REQ-021 Load writeback: wb_data=mem_rdata when mem_to_reg=1, else alu_result; store writeback: wb_reg_write=0.
REQ-022 mem_ack outside ACCESS is ignored.
REQ-023 wb_reg_write is forced 0 whenever wb_write_reg=0.
REQ-024 Memory op with alu_result[1:0]!=0: no mem_req; next cycle wb_valid=1, wb_reg_write=0, misaligned=1 for one cycle; FSM stays IDLE.
REQ-025 Wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack; counter reaching MAX_WAIT with no ack: mem_req drops, timeout=1 and wb_valid=1 with wb_reg_write=0 for one cycle, FSM->IDLE.
REQ-026 mem_ack in the same cycle the counter reaches MAX_WAIT counts as success, not timeout.
REQ-027 wb_valid=0 in every cycle without a completion; downstream applies no backpressure.
REQ-028 Back-to-back non-memory ops sustain one op per cycle.

Reset
REQ-029 rst=0 immediately forces FSM=IDLE, counter=0 and all outputs 0 except in_ready=1, including mid-access (mem_req drops without waiting for clk).
REQ-030 An in-flight access aborted by reset produces no writeback, and a later mem_ack for it is ignored.

Structure
REQ-031 FSM state encoding and the default MAX_WAIT constant are in the shared CPU package.
REQ-032 One sub-module, mem_wait_timer (counter plus expiry compare), is instantiated.

Verification
REQ-033 Add (alu_result=0x10, reg_write=1, write_reg=3): next cycle wb_valid=1, wb_data=0x10, wb_write_reg=3, no mem_req.
REQ-034 Load at 0x40, ack after 3 cycles with rdata=0xDEADBEEF: mem_req high for 3 cycles, one cycle later wb_data=0xDEADBEEF, in_ready low throughout.
REQ-035 Store 0xCAFEF00D at 0x44, immediate ack: mem_we=1, mem_wdata=0xCAFEF00D, wb_reg_write=0.
REQ-036 Load at 0x42: misaligned pulses once, no mem_req, wb_reg_write=0.
REQ-037 Load with no ack, MAX_WAIT=4: mem_req high 4 cycles, timeout pulses, FSM IDLE; repeat with ack on cycle 4 and no timeout.
REQ-038 rst=0 mid-ACCESS: mem_req=0 asynchronously, no wb_valid, later stray mem_ack ignored.
